// File: rtl/dds_wavegen_if.sv
// -----------------------------------------------------------------------------
// dds_wavegen_if
// Control and sample bus of the DDS waveform generator.
//   master : drives en, phase_clr, tune_word, wave_sel, atten; receives samples
//   slave  : the generator side (consumes controls, produces sample/sample_valid)
// Signals:
//   en           advance accumulator and launch one sample per cycle
//   phase_clr    synchronous accumulator clear (wins over en)
//   tune_word    phase increment per enabled cycle
//   wave_sel     0 sine, 1 square, 2 triangle, 3 sawtooth
//   atten        arithmetic right shift of the signed amplitude
//   sample       offset-binary output sample
//   sample_valid sample register holds a sample launched with en=1
// -----------------------------------------------------------------------------
interface dds_wavegen_if #(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned DATA_W  = 8
);
    logic               en;
    logic               phase_clr;
    logic [PHASE_W-1:0] tune_word;
    logic [1:0]         wave_sel;
    logic [2:0]         atten;
    logic [DATA_W-1:0]  sample;
    logic               sample_valid;

    modport master (
        output en,
        output phase_clr,
        output tune_word,
        output wave_sel,
        output atten,
        input  sample,
        input  sample_valid
    );

    modport slave (
        input  en,
        input  phase_clr,
        input  tune_word,
        input  wave_sel,
        input  atten,
        output sample,
        output sample_valid
    );
endinterface

// File: rtl/dds_wavegen.sv
// -----------------------------------------------------------------------------
// dds_wavegen
// Direct-digital-synthesis waveform generator running on the system clock.
// A PHASE_W-bit accumulator advances by tune_word on every enabled cycle; the
// phase feeds a 3-stage pipeline producing sine (quarter-wave LUT), square,
// triangle or sawtooth with power-of-two attenuation, in offset binary.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dds_wavegen_if.slave (controls in, sample/sample_valid out)
// -----------------------------------------------------------------------------
module dds_wavegen #(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LUT_AW  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    dds_wavegen_if.slave  bus
);

    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam int unsigned       MAX_SH   = DATA_W - 1;
    localparam int unsigned       LUT_SIZE = 2 ** LUT_AW;

    // Quarter-wave sine magnitude, sampled at bin centres so the four
    // quadrants mirror exactly without duplicated end points.
    function automatic logic [DATA_W-2:0] lut_entry(input int unsigned idx);
        real amp;
        real ang;
        amp = real'((2 ** (DATA_W - 1)) - 1);
        ang = (real'(idx) + 0.5) * 3.14159265358979323846 / real'(2 ** (LUT_AW + 1));
        return (DATA_W-1)'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    logic [DATA_W-2:0] w_lut [LUT_SIZE];

    for (genvar gi = 0; gi < LUT_SIZE; gi++) begin : g_lut
        assign w_lut[gi] = lut_entry(gi);
    end

    // ---------------- accumulator + S1 ----------------
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_p1;
    logic [1:0]         r_sel1;
    logic [2:0]         r_att1;
    logic               r_v1;
    logic               w_launch;

    assign w_launch = bus.en & ~bus.phase_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_p1   <= '0;
            r_sel1 <= '0;
            r_att1 <= '0;
            r_v1   <= 1'b0;
        end else begin
            if (bus.phase_clr) begin
                r_acc <= '0;
            end else if (bus.en) begin
                r_acc <= r_acc + bus.tune_word;
            end
            // Phase, waveform and attenuation travel together so a control
            // change takes effect cleanly on a sample boundary.
            if (w_launch) begin
                r_p1   <= r_acc;
                r_sel1 <= bus.wave_sel;
                r_att1 <= bus.atten;
            end
            r_v1 <= w_launch;
        end
    end

    // ---------------- S2: raw waveform ----------------
    logic [1:0]        w_q;
    logic [LUT_AW-1:0] w_a;
    logic [LUT_AW-1:0] w_addr;
    logic [DATA_W-1:0] w_mag;
    logic [DATA_W-1:0] w_tri;
    logic [DATA_W-1:0] w_raw;

    always_comb begin
        w_q    = r_p1[PHASE_W-1 -: 2];
        w_a    = r_p1[PHASE_W-3 -: LUT_AW];
        // Odd quadrants read the table backwards.
        w_addr = w_q[0] ? ~w_a : w_a;
        w_mag  = {1'b0, w_lut[w_addr]};
        w_tri  = r_p1[PHASE_W-2 -: DATA_W];
        w_raw  = MID;
        unique case (r_sel1)
            2'd0: w_raw = w_q[1] ? (MID - w_mag) : (MID + w_mag);
            2'd1: w_raw = r_p1[PHASE_W-1] ? '0 : '1;
            2'd2: w_raw = r_p1[PHASE_W-1] ? ~w_tri : w_tri;
            2'd3: w_raw = r_p1[PHASE_W-1 -: DATA_W];
            default: w_raw = MID;
        endcase
    end

    logic [DATA_W-1:0] r_raw2;
    logic [2:0]        r_att2;
    logic              r_v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw2 <= MID;
            r_att2 <= '0;
            r_v2   <= 1'b0;
        end else begin
            if (r_v1) begin
                r_raw2 <= w_raw;
                r_att2 <= r_att1;
            end
            r_v2 <= r_v1;
        end
    end

    // ---------------- S3: attenuation ----------------
    // One guard bit keeps the signed swing (-mid .. mid-1) representable.
    logic signed [DATA_W:0] w_diff;
    logic signed [DATA_W:0] w_shifted;
    int unsigned            w_shamt;
    logic [DATA_W-1:0]      w_out;

    always_comb begin
        w_diff    = $signed({1'b0, r_raw2}) - $signed({1'b0, MID});
        w_shamt   = (32'(r_att2) > MAX_SH) ? MAX_SH : 32'(r_att2);
        w_shifted = w_diff >>> w_shamt;
        w_out     = MID + w_shifted[DATA_W-1:0];
    end

    logic [DATA_W-1:0] r_sample;
    logic              r_sample_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample       <= MID;
            r_sample_valid <= 1'b0;
        end else begin
            if (r_v2) begin
                r_sample <= w_out;
            end
            r_sample_valid <= r_v2;
        end
    end

    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_sample_valid;

endmodule

// File: tb/tb_dds_wavegen.sv
// -----------------------------------------------------------------------------
// tb_dds_wavegen
// Directed bench for dds_wavegen (PHASE_W=16, DATA_W=8, LUT_AW=6).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_dds_wavegen;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;
    int   buff [0:1023];
    int   ok;

    dds_wavegen_if #(.PHASE_W(16), .DATA_W(8)) bus ();

    dds_wavegen #(
        .PHASE_W (16),
        .DATA_W  (8),
        .LUT_AW  (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse away from the edge, then start a stream.
    task automatic start(input logic [1:0] sel, input logic [2:0] att, input logic [15:0] tune);
        bus.en        = 1'b0;
        bus.phase_clr = 1'b0;
        rst_n         = 1'b0;
        #1;
        rst_n         = 1'b1;
        bus.wave_sel  = sel;
        bus.atten     = att;
        bus.tune_word = tune;
        bus.en        = 1'b1;
    endtask

    // Collect n consecutive samples; buff[k] is the sample of phase k*tune.
    task automatic collect(input int n);
        step();
        step();
        for (int k = 0; k < n; k++) begin
            step();
            buff[k] = int'(bus.sample);
            if (k == 0) check("stream_valid", int'(bus.sample_valid), 1);
        end
    endtask

    initial begin
        n_run         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.phase_clr = 1'b0;
        bus.wave_sel  = 2'd3;
        bus.atten     = 3'd0;
        bus.tune_word = 16'h0100;

        // ---- reset state, sawtooth from reset ----
        step();
        check("rst_sample", int'(bus.sample), 128);
        check("rst_valid", int'(bus.sample_valid), 0);
        rst_n  = 1'b1;
        bus.en = 1'b1;
        step();
        check("saw_valid_e1", int'(bus.sample_valid), 0);
        step();
        check("saw_valid_e2", int'(bus.sample_valid), 0);
        check("saw_sample_e2", int'(bus.sample), 128);
        for (int k = 0; k <= 256; k++) begin
            step();
            check("saw_sample", int'(bus.sample), k % 256);
            if (k == 0 || k == 256) check("saw_valid", int'(bus.sample_valid), 1);
        end

        // ---- sine ----
        start(2'd0, 3'd0, 16'h0400);
        collect(65);
        check("sin_0000", buff[0], 130);
        check("sin_4000", buff[16], 255);
        check("sin_8000", buff[32], 126);
        check("sin_C000", buff[48], 1);
        check("sin_period", buff[64], buff[0]);
        ok = 1;
        for (int n = 0; n < 32; n++) if (buff[n] + buff[n+32] != 256) ok = 0;
        check("sin_halfwave_sum", ok, 1);

        // ---- square, attenuated ----
        start(2'd1, 3'd1, 16'h0400);
        collect(64);
        check("sq1_first", buff[0], 191);
        check("sq1_last_hi", buff[31], 191);
        check("sq1_first_lo", buff[32], 64);
        check("sq1_last_lo", buff[63], 64);
        start(2'd1, 3'd7, 16'h0400);
        collect(64);
        check("sq7_hi", buff[0], 128);
        check("sq7_lo", buff[32], 127);

        // ---- triangle ----
        start(2'd2, 3'd0, 16'h0080);
        collect(512);
        check("tri_0000", buff[0], 0);
        check("tri_7F80", buff[255], 255);
        check("tri_8000", buff[256], 255);
        check("tri_FF80", buff[511], 0);
        ok = 1;
        for (int k = 0; k < 255; k++) if (buff[k+1] < buff[k]) ok = 0;
        check("tri_rise_mono", ok, 1);
        ok = 1;
        for (int k = 256; k < 511; k++) if (buff[k+1] > buff[k]) ok = 0;
        check("tri_fall_mono", ok, 1);

        // ---- en low for 5 cycles ----
        start(2'd3, 3'd0, 16'h0100);
        repeat (12) step();
        check("ctl_pre_sample", int'(bus.sample), 9);
        bus.en = 1'b0;
        step();
        check("ctl_drain1_s", int'(bus.sample), 10);
        check("ctl_drain1_v", int'(bus.sample_valid), 1);
        step();
        check("ctl_drain2_s", int'(bus.sample), 11);
        check("ctl_drain2_v", int'(bus.sample_valid), 1);
        step();
        check("ctl_drop_v", int'(bus.sample_valid), 0);
        check("ctl_drop_s", int'(bus.sample), 11);
        step();
        step();
        check("ctl_frozen_s", int'(bus.sample), 11);
        check("ctl_frozen_v", int'(bus.sample_valid), 0);
        bus.en = 1'b1;
        step();
        check("ctl_resume_e1_v", int'(bus.sample_valid), 0);
        step();
        check("ctl_resume_e2_v", int'(bus.sample_valid), 0);
        step();
        check("ctl_resume_s", int'(bus.sample), 12);
        check("ctl_resume_v", int'(bus.sample_valid), 1);

        // ---- phase_clr with en ----
        bus.phase_clr = 1'b1;
        step();
        bus.phase_clr = 1'b0;
        check("clr_e1_s", int'(bus.sample), 13);
        step();
        check("clr_e2_s", int'(bus.sample), 14);
        step();
        check("clr_gap_v", int'(bus.sample_valid), 0);
        check("clr_gap_s", int'(bus.sample), 14);
        step();
        check("clr_restart_s", int'(bus.sample), 0);
        check("clr_restart_v", int'(bus.sample_valid), 1);
        step();
        check("clr_next_s", int'(bus.sample), 1);

        // ---- wave_sel switch mid-stream ----
        bus.wave_sel = 2'd1;
        step();
        check("sel_old1", int'(bus.sample), 2);
        step();
        check("sel_old2", int'(bus.sample), 3);
        step();
        check("sel_new", int'(bus.sample), 255);

        // ---- asynchronous reset mid-stream ----
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sample", int'(bus.sample), 128);
        check("arst_valid", int'(bus.sample_valid), 0);
        step();
        rst_n        = 1'b1;
        bus.wave_sel = 2'd3;
        step();
        step();
        check("arst_refill_v", int'(bus.sample_valid), 0);
        step();
        check("arst_first_s", int'(bus.sample), 0);
        check("arst_first_v", int'(bus.sample_valid), 1);
        step();
        check("arst_second_s", int'(bus.sample), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_wavegen.md
Name: dds_wavegen

Overview:
- Parametrised direct-digital-synthesis waveform generator.
- Successor to the fixed 256-entry, 8-bit sine table stepped by a divided clock.
- Runs on the system clock with a PHASE_W-bit phase accumulator and programmable tuning word, so the divided-clock module is not needed.
- Produces sine (quarter-wave LUT), square, triangle or sawtooth, with power-of-two attenuation; output is offset-binary and feeds the DAC/PWM path.

Parameters:
- PHASE_W, 16, phase accumulator width; must be >= DATA_W+2 and >= LUT_AW+2.
- DATA_W, 8, output sample width (offset binary, mid-scale = 2^(DATA_W-1)).
- LUT_AW, 6, quarter-wave sine table address width (2^LUT_AW entries).

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, advance accumulator and launch one sample per cycle while high.
- phase_clr, in, 1, synchronous clear of accumulator.
- tune_word, in, PHASE_W, phase increment per enabled cycle.
- wave_sel, in, 2, waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- atten, in, 3, arithmetic right-shift of signed amplitude (0 = full scale).
- sample, out, DATA_W, offset-binary output sample.
- sample_valid, out, 1, sample register holds a sample launched with en=1.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release): acc=0, all pipeline valids=0, sample=2^(DATA_W-1), sample_valid=0. Reset mid-run discards in-flight samples immediately.

Accumulator:
- phase_clr=1 -> acc<=0. Takes priority over en; no sample is launched that cycle.
- Else en=1 -> acc<=acc+tune_word, modulo 2^PHASE_W (wrap silent, no flag).
- Else acc holds.

Pipeline: 3 stages, valid bit per stage. An edge with en=1 and phase_clr=0 is edge k.
- S1 (edge k): capture current acc (pre-increment), wave_sel and atten; v1<=1. These inputs are sampled together so mid-stream changes are glitch-coherent. Otherwise v1<=0.
- S2 (edge k+1): compute raw unsigned DATA_W value r from S1 contents; v2<=v1.
- S3 (edge k+2): sample <= mid + (signed(r - mid) >>> atten); sample_valid<=v2. When v2=0, sample holds its last value.
- Latency: sample for the phase captured at edge k is visible after edge k+2. Continuous en gives one sample per clock.
- en low: sample_valid falls 2 edges after the first edge with en=0 (pipeline drains); sample then holds.

Waveforms (p = S1 phase, q = p[PHASE_W-1:PHASE_W-2], a = p[PHASE_W-3 -: LUT_AW]):
- Sine:
  - LUT entry i = round((2^(DATA_W-1)-1) * sin((i+0.5)*pi/2^(LUT_AW+1))), unsigned DATA_W-1 bits; built in an initial block or function.
  - Address = a for q=0,2; ~a for q=1,3.
  - r = mid+mag for q=0,1; r = mid-mag for q=2,3. Output range is 1..2^DATA_W-1.
- Square: r = 2^DATA_W-1 when p[MSB]=0, else 0.
- Sawtooth: r = p[PHASE_W-1 -: DATA_W].
- Triangle: t = p[PHASE_W-2 -: DATA_W]; r = t when p[MSB]=0, else ~t.
- Attenuation: signed arithmetic with one guard bit; shift saturates at DATA_W-1 (atten >= DATA_W-1 -> sample is mid or mid-1).

Test Plan:
- Reset: assert rst_n=0 mid-stream -> sample=128 and sample_valid=0 immediately (asynchronous); acc restarts from 0 after release.
- Sawtooth, tune_word=0x0100, en=1 from reset -> sample_valid rises after 3rd edge; samples 0,1,2,...,255,0 (wrap after 256), one per clock.
- Sine, tune_word=0x0400:
  - phase 0x0000 -> 130; 0x4000 -> 255; 0x8000 -> 126; 0xC000 -> 1.
  - 64-sample period; samples s[n] and s[n+32] sum to 256.
- Square, atten=1 -> alternating 191 (first half-period) / 64; atten=7 -> 128/127.
- Triangle, tune_word=0x0080: phase 0x0000 -> 0; 0x7F80 -> 255; 0x8000 -> 255; 0xFF80 -> 0. Ramp is monotonic on each half.
- Control:
  - en low for 5 cycles -> sample_valid drops 2 edges later, sample frozen; resume continues phase without a skip.
  - phase_clr and en together high -> acc=0; no sample launched that cycle.
  - wave_sel changed mid-stream -> switch is clean at the S1 boundary.
